// File: rtl/icache_sa.sv
// icache_sa: 2-way set-associative I-cache, word-serial refill; define ICACHE_STATS_EN for hit/miss counters
module icache_sa #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              invalidate,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam logic [1:0] IDLE = 2'd0, REFILL = 2'd1, RESP = 2'd2;
  logic [1:0]          state;
  logic [ADDR_W-1:2]   addr_q, a;
  logic [OFFSET_W-1:0] cnt, off;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                vic_q, inv_pend, hit0, hit1, hit, victim, rsp_way;
  logic                lookup_hit, lookup_miss, unused;
  logic [31:0]         data_m [2][SETS][WORDS];
  logic [TAG_W-1:0]    tag_m [2][SETS];
  logic [SETS-1:0]     valid_m [2];
  logic [SETS-1:0]     lru;
  assign unused      = &{1'b0, req_addr[1:0]};
  assign a           = (state == IDLE) ? req_addr[ADDR_W-1:2] : addr_q;
  assign off         = a[OFFSET_W+1:2];
  assign idx         = a[INDEX_W+OFFSET_W+1:OFFSET_W+2];
  assign tag         = a[ADDR_W-1:ADDR_W-TAG_W];
  assign hit0        = valid_m[0][idx] && tag_m[0][idx] == tag;
  assign hit1        = valid_m[1][idx] && tag_m[1][idx] == tag;
  assign hit         = hit0 | hit1;
  assign victim      = !valid_m[0][idx] ? 1'b0 : !valid_m[1][idx] ? 1'b1 : lru[idx];
  assign lookup_hit  = state == IDLE && req_valid && !invalidate && hit;
  assign lookup_miss = state == IDLE && req_valid && !invalidate && !hit;
  assign rsp_valid   = lookup_hit || state == RESP;
  assign rsp_way     = (state == RESP) ? vic_q : !hit0;
  assign rsp_data    = rsp_valid ? data_m[rsp_way][idx][off] : '0;
  assign stall       = state == REFILL || (state == IDLE && (invalidate || lookup_miss));
  assign mem_req     = state == REFILL;
  assign mem_addr    = mem_req ? {addr_q[ADDR_W-1:OFFSET_W+2], cnt, 2'b00} : '0;
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      data_m[vic_q][idx][cnt] <= mem_data;
      if (&cnt) tag_m[vic_q][idx] <= tag;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt        <= '0;
      vic_q      <= 1'b0;
      inv_pend   <= 1'b0;
      valid_m[0] <= '0;
      valid_m[1] <= '0;
      lru        <= '0;
    end else if (state == IDLE) begin
      if (invalidate) begin
        valid_m[0] <= '0;
        valid_m[1] <= '0;
      end else if (lookup_hit) begin
        lru[idx] <= hit0;
      end else if (lookup_miss) begin
        addr_q <= req_addr[ADDR_W-1:2];
        vic_q  <= victim;
        cnt    <= '0;
        state  <= REFILL;
      end
    end else if (state == REFILL) begin
      if (invalidate) inv_pend <= 1'b1;
      if (mem_ack) begin
        cnt <= cnt + OFFSET_W'(1);
        if (&cnt) begin
          valid_m[vic_q][idx] <= 1'b1;
          lru[idx]            <= !vic_q;
          state               <= RESP;
        end
      end
    end else begin
      if (inv_pend || invalidate) begin
        valid_m[0] <= '0;
        valid_m[1] <= '0;
      end
      inv_pend <= 1'b0;
      state    <= IDLE;
    end
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      hit_cnt  <= hit_cnt + 32'(lookup_hit);
      miss_cnt <= miss_cnt + 32'(lookup_miss);
    end
  end
`endif
endmodule
